// File: rtl/aurora_flow_pkg.sv
// Shared definitions for the Aurora RX native-flow-control stage: NFC payload width,
// default XOFF/XON payloads, FSM state encoding and the hold-counter reload helper.
package aurora_flow_pkg;

   localparam int unsigned NFC_W = 16;

   localparam logic [NFC_W-1:0] NFC_XOFF_DEF = 16'h0001;
   localparam logic [NFC_W-1:0] NFC_XON_DEF  = 16'h0000;

   typedef enum logic [1:0] {
      NFC_IDLE      = 2'd0,
      NFC_SEND_XOFF = 2'd1,
      NFC_PAUSED    = 2'd2,
      NFC_SEND_XON  = 2'd3
   } nfc_state_e;

   // PAUSED lasts MIN_HOLD cycles, so the counter starts one below that.
   function automatic logic [15:0] hold_load(input int unsigned min_hold);
      return 16'(min_hold - 1);
   endfunction

endpackage

// File: rtl/aurora_flow_nfc_if.sv
// NFC AXI-Stream request channel between the flow-control stage (master) and the
// Aurora core's native-flow-control port (slave).
interface aurora_flow_nfc_if;
   import aurora_flow_pkg::*;

   logic             s_axi_nfc_tvalid;
   logic [NFC_W-1:0] s_axi_nfc_tdata;
   logic             s_axi_nfc_tready;

   modport master (
      output s_axi_nfc_tvalid,
      output s_axi_nfc_tdata,
      input  s_axi_nfc_tready
   );

   modport slave (
      input  s_axi_nfc_tvalid,
      input  s_axi_nfc_tdata,
      output s_axi_nfc_tready
   );

endinterface

// File: rtl/aurora_flow_sat_cnt.sv
// Saturating status counter: increments on inc_i, sticks at all-ones, and a synchronous
// clear wins over a same-cycle increment.
module aurora_flow_sat_cnt
   import aurora_flow_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             user_clk,
   input  logic             rst_u,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !(&cnt_q)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge user_clk or posedge rst_u) begin
      if (rst_u) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/aurora_flow_nfc.sv
// RX-side native flow control: pauses the link partner with XOFF when the RX FIFO nears
// full, resumes with XON after a minimum hold, and keeps overflow / pause statistics.
module aurora_flow_nfc
   import aurora_flow_pkg::*;
#(
   parameter logic [NFC_W-1:0] NFC_XOFF = NFC_XOFF_DEF,
   parameter logic [NFC_W-1:0] NFC_XON  = NFC_XON_DEF,
   parameter int unsigned      MIN_HOLD = 16,
   parameter int unsigned      CNT_W    = 32
) (
   input  logic                user_clk,
   input  logic                rst_u,
   input  logic                channel_up_u,
   input  logic                fifo_rx_prog_full_u,
   input  logic                rx_tvalid_u,
   input  logic                rx_tready_u,
   input  logic                counter_clear_u,
   aurora_flow_nfc_if.master   nfc,
   output logic                xoff_active_u,
   output logic                overflow_sticky_u,
   output logic [CNT_W-1:0]    xoff_count_u,
   output logic [CNT_W-1:0]    paused_cycles_u,
   output logic [CNT_W-1:0]    overflow_count_u
);

   localparam logic [1:0]  ST_IDLE      = NFC_IDLE;
   localparam logic [1:0]  ST_SEND_XOFF = NFC_SEND_XOFF;
   localparam logic [1:0]  ST_PAUSED    = NFC_PAUSED;
   localparam logic [1:0]  ST_SEND_XON  = NFC_SEND_XON;
   localparam logic [15:0] HOLD_LOAD    = hold_load(MIN_HOLD);

   logic [1:0]       state_q, state_d;
   logic             tvalid_q, tvalid_d;
   logic [NFC_W-1:0] tdata_q, tdata_d;
   logic [15:0]      hold_q, hold_d;
   logic             xoff_active_q, xoff_active_d;
   logic             sticky_q, sticky_d;
   logic             handshake;
   logic             xoff_inc;
   logic             ovf_beat;

   assign handshake = tvalid_q && nfc.s_axi_nfc_tready;
   assign ovf_beat  = rx_tvalid_u && !rx_tready_u;

   always_comb begin
      state_d  = state_q;
      tvalid_d = tvalid_q;
      tdata_d  = tdata_q;
      hold_d   = hold_q;
      xoff_inc = 1'b0;
      // Losing the channel is the only way a request is withdrawn without a handshake.
      if (!channel_up_u) begin
         state_d  = ST_IDLE;
         tvalid_d = 1'b0;
         hold_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (fifo_rx_prog_full_u) begin
                  state_d  = ST_SEND_XOFF;
                  tvalid_d = 1'b1;
                  tdata_d  = NFC_XOFF;
               end
            end
            ST_SEND_XOFF: begin
               if (handshake) begin
                  state_d  = ST_PAUSED;
                  tvalid_d = 1'b0;
                  hold_d   = HOLD_LOAD;
                  xoff_inc = 1'b1;
               end
            end
            ST_PAUSED: begin
               if (hold_q != 16'd0) begin
                  hold_d = hold_q - 16'd1;
               end else if (!fifo_rx_prog_full_u) begin
                  state_d  = ST_SEND_XON;
                  tvalid_d = 1'b1;
                  tdata_d  = NFC_XON;
               end
            end
            ST_SEND_XON: begin
               if (handshake) begin
                  state_d  = ST_IDLE;
                  tvalid_d = 1'b0;
               end
            end
         endcase
      end
      xoff_active_d = (state_d != ST_IDLE);
   end

   always_comb begin
      sticky_d = sticky_q;
      if (counter_clear_u) begin
         sticky_d = 1'b0;
      end else if (ovf_beat) begin
         sticky_d = 1'b1;
      end
   end

   always_ff @(posedge user_clk or posedge rst_u) begin
      if (rst_u) begin
         state_q       <= ST_IDLE;
         tvalid_q      <= 1'b0;
         tdata_q       <= NFC_XON;
         hold_q        <= '0;
         xoff_active_q <= 1'b0;
         sticky_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         tvalid_q      <= tvalid_d;
         tdata_q       <= tdata_d;
         hold_q        <= hold_d;
         xoff_active_q <= xoff_active_d;
         sticky_q      <= sticky_d;
      end
   end

   aurora_flow_sat_cnt #(.CNT_W(CNT_W)) u_xoff_cnt (
      .user_clk (user_clk),
      .rst_u    (rst_u),
      .inc_i    (xoff_inc),
      .clr_i    (counter_clear_u),
      .cnt_o    (xoff_count_u)
   );

   aurora_flow_sat_cnt #(.CNT_W(CNT_W)) u_paused_cnt (
      .user_clk (user_clk),
      .rst_u    (rst_u),
      .inc_i    (xoff_active_q),
      .clr_i    (counter_clear_u),
      .cnt_o    (paused_cycles_u)
   );

   aurora_flow_sat_cnt #(.CNT_W(CNT_W)) u_ovf_cnt (
      .user_clk (user_clk),
      .rst_u    (rst_u),
      .inc_i    (ovf_beat),
      .clr_i    (counter_clear_u),
      .cnt_o    (overflow_count_u)
   );

   assign nfc.s_axi_nfc_tvalid = tvalid_q;
   assign nfc.s_axi_nfc_tdata  = tdata_q;
   assign xoff_active_u        = xoff_active_q;
   assign overflow_sticky_u    = sticky_q;

endmodule

// File: tb/tb_aurora_flow_nfc.sv
// Directed bench for aurora_flow_nfc: NFC beats checked against a payload scoreboard,
// status outputs checked against hand-derived values; a narrow-counter copy shows saturation.
module tb_aurora_flow_nfc;
   import aurora_flow_pkg::*;

   logic user_clk = 1'b0;
   logic rst_u;
   logic channel_up_u, fifo_rx_prog_full_u, rx_tvalid_u, rx_tready_u, counter_clear_u;
   logic        xoff_active_u, overflow_sticky_u;
   logic [31:0] xoff_count_u, paused_cycles_u, overflow_count_u;

   logic       s_xoff_active, s_sticky;
   logic [2:0] s_xoff_cnt, s_paused_cnt, s_ovf_cnt;

   int checks = 0;
   int errors = 0;
   logic [NFC_W-1:0] exp_q[$];

   aurora_flow_nfc_if nfc ();
   aurora_flow_nfc_if nfc_s ();

   always #5 user_clk = ~user_clk;

   aurora_flow_nfc dut (
      .user_clk            (user_clk),
      .rst_u               (rst_u),
      .channel_up_u        (channel_up_u),
      .fifo_rx_prog_full_u (fifo_rx_prog_full_u),
      .rx_tvalid_u         (rx_tvalid_u),
      .rx_tready_u         (rx_tready_u),
      .counter_clear_u     (counter_clear_u),
      .nfc                 (nfc.master),
      .xoff_active_u       (xoff_active_u),
      .overflow_sticky_u   (overflow_sticky_u),
      .xoff_count_u        (xoff_count_u),
      .paused_cycles_u     (paused_cycles_u),
      .overflow_count_u    (overflow_count_u)
   );

   // Same stimulus, 3-bit counters, so saturation is reachable in a few beats.
   aurora_flow_nfc #(.CNT_W(3)) dut_small (
      .user_clk            (user_clk),
      .rst_u               (rst_u),
      .channel_up_u        (channel_up_u),
      .fifo_rx_prog_full_u (fifo_rx_prog_full_u),
      .rx_tvalid_u         (rx_tvalid_u),
      .rx_tready_u         (rx_tready_u),
      .counter_clear_u     (counter_clear_u),
      .nfc                 (nfc_s.master),
      .xoff_active_u       (s_xoff_active),
      .overflow_sticky_u   (s_sticky),
      .xoff_count_u        (s_xoff_cnt),
      .paused_cycles_u     (s_paused_cnt),
      .overflow_count_u    (s_ovf_cnt)
   );

   assign nfc_s.s_axi_nfc_tready = 1'b1;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge user_clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // A handshake completes at the next rising edge; pop the expected payload for it.
   always @(negedge user_clk) begin
      if (!rst_u && nfc.s_axi_nfc_tvalid && nfc.s_axi_nfc_tready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_nfc_beat", {16'h0, nfc.s_axi_nfc_tdata}, 32'hDEAD_BEEF);
         end else begin
            chk("nfc_payload", {16'h0, nfc.s_axi_nfc_tdata}, {16'h0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      rst_u = 1'b1;
      channel_up_u = 1'b1;
      fifo_rx_prog_full_u = 1'b0;
      rx_tvalid_u = 1'b0;
      rx_tready_u = 1'b1;
      counter_clear_u = 1'b0;
      nfc.s_axi_nfc_tready = 1'b1;

      // 1: reset values
      tick(3);
      chk("rst_tvalid", {31'h0, nfc.s_axi_nfc_tvalid}, 32'h0);
      chk("rst_tdata", {16'h0, nfc.s_axi_nfc_tdata}, 32'h0);
      chk("rst_xoff_active", {31'h0, xoff_active_u}, 32'h0);
      chk("rst_sticky", {31'h0, overflow_sticky_u}, 32'h0);
      chk("rst_xoff_cnt", xoff_count_u, 32'h0);
      chk("rst_paused_cnt", paused_cycles_u, 32'h0);
      chk("rst_ovf_cnt", overflow_count_u, 32'h0);
      rst_u = 1'b0;
      tick(7);
      chk("idle_tvalid", {31'h0, nfc.s_axi_nfc_tvalid}, 32'h0);
      chk("idle_paused_cnt", paused_cycles_u, 32'h0);

      // 2: XOFF with tready tied high, then XON after the minimum hold
      fifo_rx_prog_full_u = 1'b1;
      exp_q.push_back(16'h0001);
      tick(1);
      chk("xoff_tvalid", {31'h0, nfc.s_axi_nfc_tvalid}, 32'h1);
      chk("xoff_tdata", {16'h0, nfc.s_axi_nfc_tdata}, 32'h0001);
      chk("xoff_active", {31'h0, xoff_active_u}, 32'h1);
      tick(1);
      chk("xoff_one_beat", {31'h0, nfc.s_axi_nfc_tvalid}, 32'h0);
      chk("xoff_cnt_1", xoff_count_u, 32'h1);
      tick(2);
      fifo_rx_prog_full_u = 1'b0;
      exp_q.push_back(16'h0000);
      tick(13);
      chk("hold_no_early_xon", {31'h0, nfc.s_axi_nfc_tvalid}, 32'h0);
      chk("hold_still_active", {31'h0, xoff_active_u}, 32'h1);
      tick(1);
      chk("xon_tvalid", {31'h0, nfc.s_axi_nfc_tvalid}, 32'h1);
      chk("xon_tdata", {16'h0, nfc.s_axi_nfc_tdata}, 32'h0000);
      tick(1);
      chk("xon_done_tvalid", {31'h0, nfc.s_axi_nfc_tvalid}, 32'h0);
      chk("xon_done_active", {31'h0, xoff_active_u}, 32'h0);
      chk("paused_cnt_18", paused_cycles_u, 32'd18);
      chk("xoff_cnt_still_1", xoff_count_u, 32'h1);

      // 3: back-pressured XOFF holds stable until accepted
      nfc.s_axi_nfc_tready = 1'b0;
      fifo_rx_prog_full_u = 1'b1;
      exp_q.push_back(16'h0001);
      tick(1);
      chk("bp_tvalid_0", {31'h0, nfc.s_axi_nfc_tvalid}, 32'h1);
      for (int i = 0; i < 7; i++) begin
         tick(1);
         chk("bp_tvalid", {31'h0, nfc.s_axi_nfc_tvalid}, 32'h1);
         chk("bp_tdata", {16'h0, nfc.s_axi_nfc_tdata}, 32'h0001);
         chk("bp_xoff_cnt", xoff_count_u, 32'h1);
      end
      nfc.s_axi_nfc_tready = 1'b1;
      tick(1);
      chk("bp_done_tvalid", {31'h0, nfc.s_axi_nfc_tvalid}, 32'h0);
      chk("bp_xoff_cnt_2", xoff_count_u, 32'h2);

      // 4: channel down while paused -> IDLE, no XON
      channel_up_u = 1'b0;
      tick(1);
      chk("chdn_active", {31'h0, xoff_active_u}, 32'h0);
      chk("chdn_tvalid", {31'h0, nfc.s_axi_nfc_tvalid}, 32'h0);
      tick(3);
      chk("chdn_stay_tvalid", {31'h0, nfc.s_axi_nfc_tvalid}, 32'h0);
      chk("chdn_paused_cnt", paused_cycles_u, 32'd27);
      chk("chdn_xoff_cnt", xoff_count_u, 32'h2);
      fifo_rx_prog_full_u = 1'b0;
      channel_up_u = 1'b1;
      tick(2);
      chk("chup_no_xon", {31'h0, nfc.s_axi_nfc_tvalid}, 32'h0);

      // 5: overflow counting, accepted beats ignored, clear wins over increment
      rx_tvalid_u = 1'b1;
      rx_tready_u = 1'b1;
      tick(2);
      chk("accept_no_ovf", overflow_count_u, 32'h0);
      chk("accept_no_sticky", {31'h0, overflow_sticky_u}, 32'h0);
      rx_tready_u = 1'b0;
      tick(3);
      chk("ovf_cnt_3", overflow_count_u, 32'd3);
      chk("ovf_sticky", {31'h0, overflow_sticky_u}, 32'h1);
      counter_clear_u = 1'b1;
      tick(1);
      counter_clear_u = 1'b0;
      chk("clr_ovf_cnt", overflow_count_u, 32'h0);
      chk("clr_sticky", {31'h0, overflow_sticky_u}, 32'h0);
      chk("clr_xoff_cnt", xoff_count_u, 32'h0);
      chk("clr_paused_cnt", paused_cycles_u, 32'h0);
      chk("clr_small_ovf", {29'h0, s_ovf_cnt}, 32'h0);

      // 6: saturation on the 3-bit copy (all-ones minus 1, then 3 more beats)
      tick(6);
      chk("sat_pre_small", {29'h0, s_ovf_cnt}, 32'd6);
      chk("sat_pre_main", overflow_count_u, 32'd6);
      tick(3);
      chk("sat_hold_small", {29'h0, s_ovf_cnt}, 32'd7);
      chk("sat_main_9", overflow_count_u, 32'd9);
      rx_tvalid_u = 1'b0;
      tick(2);

      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
